pipe_field: RTL
===============

# pipe_field

Parametrised pipe generator and renderer for the Flappy Bird datapath. Holds `NUM_PIPES` scrolling pipes in a fixed ring order and moves them left at a divided tick rate. Respawns each expired pipe behind its ring predecessor with a fresh gap. Produces a registered pipe pixel for the VGA colour mux, a sticky bird/pipe collision flag and a saturating score.

## Interface
Parameters:
- `NUM_PIPES`, 4: number of pipes, legal range 2..8.
- `PIPE_WIDTH`, 40: pipe width in pixels.
- `PIPE_SPEED`, 1: pixels moved per tick.
- `SPEED_DIVIDER`, 1_000_000: clock cycles per tick, ≥2.
- `PIPE_SPACING`, 220: ring-neighbour spacing. Must be greater than `PIPE_SPEED`.
- `RESPAWN_X`, 880: initial x of pipe 0.
- `GAP_MIN_TOP`, 60: lower clamp for the gap top.
- `GAP_MAX_TOP`, 320: upper clamp for the gap top.
- `GAP_SIZE`, 120: gap height in lines.
- `BIRD_X`, 160: scoring column.

Ports:
- `clk`, in, 1: pixel clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: 1 lets the scroll advance; 0 freezes the field.
- `restart`, in, 1: synchronous re-initialisation. Takes priority over `run`.
- `hCount`, in, 10: scan column.
- `vCount`, in, 10: scan line.
- `bird_pixel`, in, 1: bird coverage, aligned with `hCount`/`vCount`.
- `pipe_pixel`, out, 1: registered pipe coverage.
- `collision`, out, 1: sticky collision flag.
- `score`, out, 8: pipes passed, saturates at 255.
- `score_pulse`, out, 1: one-cycle strobe when `score` increments.

## Operation
- Per-pipe state:
  - `x[i]`: 11 bits.
  - `gap_top[i]`: 10 bits.
- Shared state:
  - `div_cnt`: counts 0..`SPEED_DIVIDER`-1.
  - `lfsr`: 10 bits, polynomial x^10+x^7+1, shifts left and inserts bit9^bit6.
- Init values, applied on `reset_n`=0 or `restart`=1:
  - `x[i]` = `RESPAWN_X` + i*`PIPE_SPACING`.
  - `gap_top[i]` = clamp(`GAP_MIN_TOP` + 60*i).
  - `lfsr` = 10'h3FF.
  - `div_cnt`, `score`, `collision`, `pipe_pixel`, `score_pulse` = 0.
- Tick: while `run`=1, `div_cnt` increments. At `SPEED_DIVIDER`-1 it returns to 0 and the cycle is a tick. While `run`=0, `div_cnt` and all pipe state hold.
- On a tick:
  - `lfsr` advances one step.
  - Each pipe with `x[i]` ≥ `PIPE_SPEED` moves: `x[i]` -= `PIPE_SPEED`.
  - Otherwise the pipe respawns: `x[i]` = new `x[(i-1) mod NUM_PIPES]` + `PIPE_SPACING`, where new x means the predecessor's value after this tick's move. It also loads a new gap top (see Configuration).
- Pixel test, with `hCount` zero-extended to 11 bits and sums formed 12 bits wide:
  - Pipe i covers a pixel when `x[i]` ≤ `hCount` < `x[i]`+`PIPE_WIDTH`, and not (`gap_top[i]` ≤ `vCount` < `gap_top[i]`+`GAP_SIZE`).
  - `pipe_pixel` is the OR over all pipes.
- Score: on a tick, a pipe crosses when `x`+`PIPE_WIDTH` > `BIRD_X` before the move and ≤ `BIRD_X` after it.
  - If any pipe crosses, `score` += 1 (saturating at 255) and `score_pulse` is asserted.
  - At most one increment per tick.
- Collision: `bird_pixel` is registered alongside `pipe_pixel`.
  - `collision` sets when both registered bits are 1.
  - It clears only on reset or `restart`.
  - It does not gate `run`; the game FSM upstream drops `run`.
- Clamp function: values below `GAP_MIN_TOP` become `GAP_MIN_TOP`; values above `GAP_MAX_TOP` become `GAP_MAX_TOP`.
- Width constraint: `RESPAWN_X` + `NUM_PIPES`*`PIPE_SPACING` < 2048.

## Timing
- `pipe_pixel` and `collision` have 1-cycle latency from `hCount`/`vCount`/`bird_pixel`.
- Pipe position and gap updates are visible on the cycle after the tick.
- `score` and `score_pulse` update on the cycle after the tick. `score_pulse` is high for exactly 1 cycle.
- `restart` while `run`=1 applies init on the next edge. The tick counter restarts from 0.
- `reset_n` low mid-frame immediately clears every output to 0, asynchronously.
- `run` falling on a tick cycle still applies that tick. Freezing starts on the following cycle.

## Configuration
- `PIPE_RAND_GAP_EN` defined: on respawn, `gap_top[i]` = clamp(`lfsr` ^ (10'h155*i, truncated to 10 bits)). The value of `lfsr` is taken before this tick's shift.
- `PIPE_RAND_GAP_EN` undefined: on respawn, `gap_top[i]` keeps its init value. The LFSR is omitted.

## Test plan
- Reset with default parameters:
  - `x` = 880/1100/1320/1540.
  - `gap_top` = 60/120/180/240.
  - All outputs 0.
- `SPEED_DIVIDER`=4, `run`=1 → each `x` drops by 1 every 4 cycles.
- Run with `run`=0 for 20 cycles → `x` and `div_cnt` unchanged.
- Force `x[0]`=0, with `x[3]` before its move = 700 → after the tick, `x[0]` = 699+220 = 919. Under `PIPE_RAND_GAP_EN`, `gap_top[0]` stays within 60..320.
- Pipe with `x`+40 = 161 and `BIRD_X`=160, on a tick → `score` 0→1 with a 1-cycle `score_pulse`. Preloading `score`=255 → stays at 255.
- `bird_pixel`=1 over a pipe body pixel → `collision`=1 one cycle later, still 1 after `bird_pixel` drops, 0 after `restart`.
- `PIPE_RAND_GAP_EN` undefined, pipe 1 respawns → `gap_top[1]` stays 120.

Source files
------------

// File: rtl/pipe_field.sv
// Scrolling pipe field for the Flappy Bird datapath: ring-ordered pipes, registered pixel, sticky collision, score.
// Optional macro PIPE_RAND_GAP_EN: respawned pipes take an LFSR-derived gap top instead of their init gap.
module pipe_field #(
  parameter int unsigned NUM_PIPES     = 4,
  parameter int unsigned PIPE_WIDTH    = 40,
  parameter int unsigned PIPE_SPEED    = 1,
  parameter int unsigned SPEED_DIVIDER = 1_000_000,
  parameter int unsigned PIPE_SPACING  = 220,
  parameter int unsigned RESPAWN_X     = 880,
  parameter int unsigned GAP_MIN_TOP   = 60,
  parameter int unsigned GAP_MAX_TOP   = 320,
  parameter int unsigned GAP_SIZE      = 120,
  parameter int unsigned BIRD_X        = 160
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       restart,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       bird_pixel,
  output logic       pipe_pixel,
  output logic       collision,
  output logic [7:0] score,
  output logic       score_pulse
);

  localparam int unsigned DIV_W = $clog2(SPEED_DIVIDER);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIVIDER - 1);

  function automatic logic [9:0] clamp_gap(input logic [31:0] v);
    if (v < GAP_MIN_TOP)      return 10'(GAP_MIN_TOP);
    else if (v > GAP_MAX_TOP) return 10'(GAP_MAX_TOP);
    else                      return 10'(v);
  endfunction

  function automatic logic [10:0] init_x(input int unsigned i);
    return 11'(RESPAWN_X + i * PIPE_SPACING);
  endfunction

  function automatic logic [9:0] init_gap(input int unsigned i);
    return clamp_gap(32'(GAP_MIN_TOP + 60 * i));
  endfunction

  logic [10:0]      r_x   [NUM_PIPES];
  logic [9:0]       r_gap [NUM_PIPES];
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pipe_pixel;
  logic             r_collision;
  logic [7:0]       r_score;
  logic             r_score_pulse;
`ifdef PIPE_RAND_GAP_EN
  logic [9:0]       r_lfsr;
`endif

  logic [10:0] w_moved  [NUM_PIPES];
  logic [10:0] w_x_next [NUM_PIPES];
  logic [9:0]  w_gap_next [NUM_PIPES];
  logic        w_tick;
  logic        w_cross;
  logic        w_pix;

  assign w_tick = run && (r_div_cnt == DIV_LAST);

  always_comb begin
    w_cross = 1'b0;
    w_pix   = 1'b0;
    for (int unsigned i = 0; i < NUM_PIPES; i++) begin
      w_moved[i] = (r_x[i] >= 11'(PIPE_SPEED)) ? r_x[i] - 11'(PIPE_SPEED) : r_x[i];
    end
    for (int unsigned i = 0; i < NUM_PIPES; i++) begin
      // Respawn trails the predecessor's post-move position so ring spacing is preserved.
      if (r_x[i] >= 11'(PIPE_SPEED)) begin
        w_x_next[i]   = w_moved[i];
        w_gap_next[i] = r_gap[i];
      end else begin
        w_x_next[i] = w_moved[(i + NUM_PIPES - 1) % NUM_PIPES] + 11'(PIPE_SPACING);
`ifdef PIPE_RAND_GAP_EN
        w_gap_next[i] = clamp_gap(32'(r_lfsr ^ 10'(32'h155 * i)));
`else
        w_gap_next[i] = init_gap(i);
`endif
      end
      if ((({1'b0, r_x[i]} + 12'(PIPE_WIDTH)) > 12'(BIRD_X)) &&
          (({1'b0, w_x_next[i]} + 12'(PIPE_WIDTH)) <= 12'(BIRD_X)))
        w_cross = 1'b1;
      if (({2'b0, hCount} >= {1'b0, r_x[i]}) &&
          ({2'b0, hCount} < ({1'b0, r_x[i]} + 12'(PIPE_WIDTH))) &&
          !(({2'b0, vCount} >= {2'b0, r_gap[i]}) &&
            ({2'b0, vCount} < ({2'b0, r_gap[i]} + 12'(GAP_SIZE)))))
        w_pix = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
        r_x[i]   <= init_x(i);
        r_gap[i] <= init_gap(i);
      end
      r_div_cnt     <= '0;
      r_pipe_pixel  <= 1'b0;
      r_collision   <= 1'b0;
      r_score       <= '0;
      r_score_pulse <= 1'b0;
`ifdef PIPE_RAND_GAP_EN
      r_lfsr        <= '1;
`endif
    end else if (restart) begin
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
        r_x[i]   <= init_x(i);
        r_gap[i] <= init_gap(i);
      end
      r_div_cnt     <= '0;
      r_pipe_pixel  <= 1'b0;
      r_collision   <= 1'b0;
      r_score       <= '0;
      r_score_pulse <= 1'b0;
`ifdef PIPE_RAND_GAP_EN
      r_lfsr        <= '1;
`endif
    end else begin
      r_pipe_pixel  <= w_pix;
      r_collision   <= r_collision | (w_pix & bird_pixel);
      r_score_pulse <= 1'b0;
      if (w_tick) begin
        r_div_cnt <= '0;
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
          r_x[i]   <= w_x_next[i];
          r_gap[i] <= w_gap_next[i];
        end
`ifdef PIPE_RAND_GAP_EN
        r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
`endif
        if (w_cross && (r_score != 8'hFF)) begin
          r_score       <= r_score + 8'd1;
          r_score_pulse <= 1'b1;
        end
      end else if (run) begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  assign pipe_pixel  = r_pipe_pixel;
  assign collision   = r_collision;
  assign score       = r_score;
  assign score_pulse = r_score_pulse;

endmodule
